// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// Stall bus bit order: 0=PC 1=IF 2=ID 3=EX 4=MEM 5=WB.
package pipe_stall_ctrl_pkg;

  localparam int STALL_W = 6;
  localparam int MC_MAX_CYCLES_DEF = 64;
  localparam int MC_CNT_W_DEF = 7;
  localparam int STG_ID = 2;

  typedef logic [STALL_W-1:0] stall_bus_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_LU   = 6'b000111;
  localparam stall_bus_t STALL_MC   = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;

  typedef enum logic {
    RUN     = 1'b0,
    MC_WAIT = 1'b1
  } mc_state_e;

  localparam logic Stop   = 1'b1;
  localparam logic NoStop = 1'b0;

endpackage

// File: rtl/pipe_stall_ctrl_if.sv
// Stall request / stall bus bundle between pipeline and stall controller.
// STALL_PERF_CNT_EN adds the per-cause performance counter outputs.
interface pipe_stall_ctrl_if;
  import pipe_stall_ctrl_pkg::*;

  logic       id_load_use_req;
  logic       ex_mc_start;
  logic       ex_mc_done;
  logic       mem_wait_req;
  logic [31:0] inst_sram_rdata;
  stall_bus_t stall;
  logic [31:0] id_inst;
  logic       mc_timeout;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lu_cnt;
  logic [31:0] perf_mc_cnt;
  logic [31:0] perf_mem_cnt;
`endif

  modport master (
    output id_load_use_req,
    output ex_mc_start,
    output ex_mc_done,
    output mem_wait_req,
    output inst_sram_rdata,
    input  stall,
    input  id_inst,
    input  mc_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    input  perf_lu_cnt,
    input  perf_mc_cnt,
    input  perf_mem_cnt
`endif
  );

  modport slave (
    input  id_load_use_req,
    input  ex_mc_start,
    input  ex_mc_done,
    input  mem_wait_req,
    input  inst_sram_rdata,
    output stall,
    output id_inst,
    output mc_timeout
`ifdef STALL_PERF_CNT_EN
    ,
    output perf_lu_cnt,
    output perf_mc_cnt,
    output perf_mem_cnt
`endif
  );

endinterface

// File: rtl/pipe_stall_ctrl_inst_hold_buf.sv
// ID instruction hold buffer: keeps the fetched word while ID is frozen,
// since the synchronous inst SRAM output moves on underneath it.
module inst_hold_buf
  import pipe_stall_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_stall_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] inst_o
);

  logic [31:0] hold_q, hold_d;
  logic        valid_q, valid_d;

  always_comb begin
    hold_d  = hold_q;
    valid_d = valid_q;
    if (id_stall_i == NoStop) begin
      valid_d = 1'b0;
    end else if (!valid_q) begin
      hold_d  = rdata_i;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  assign inst_o = valid_q ? hold_q : rdata_i;

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central stall controller: multicycle FSM, stall priority encoder, ID hold.
// STALL_PERF_CNT_EN adds winning-cause cycle counters.
module pipe_stall_ctrl
  import pipe_stall_ctrl_pkg::*;
#(
  parameter int MC_MAX_CYCLES = MC_MAX_CYCLES_DEF,
  parameter int MC_CNT_W      = MC_CNT_W_DEF
) (
  input  logic               clk,
  input  logic               resetn,
  pipe_stall_ctrl_if.slave   bus
);

  mc_state_e           state_q, state_d;
  logic [MC_CNT_W-1:0] mc_cnt_q, mc_cnt_d;
  logic                mc_to_q, mc_to_d;
  logic                lu_mask_q, lu_mask_d;
  logic                timeout_hit;
  logic                mc_busy;
  logic                mem_sel, mc_sel, lu_sel;
  stall_bus_t          stall_pat, stall_w;

  assign timeout_hit = (state_q == MC_WAIT) &&
                       (mc_cnt_q == MC_CNT_W'(MC_MAX_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    mc_cnt_d = mc_cnt_q;
    mc_to_d  = mc_to_q;
    mc_busy  = 1'b0;
    unique case (state_q)
      RUN: begin
        if (bus.ex_mc_start) begin
          state_d  = MC_WAIT;
          mc_cnt_d = '0;
          mc_busy  = 1'b1;
        end
      end
      MC_WAIT: begin
        if (mc_cnt_q != '1) mc_cnt_d = mc_cnt_q + 1'b1;
        // a done arriving on the last allowed cycle still counts as on time
        if (bus.ex_mc_done) begin
          state_d = RUN;
        end else if (timeout_hit) begin
          state_d = RUN;
          mc_to_d = 1'b1;
        end else begin
          mc_busy = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  assign mem_sel = bus.mem_wait_req;
  assign mc_sel  = ~bus.mem_wait_req & mc_busy;
  assign lu_sel  = ~bus.mem_wait_req & ~mc_busy &
                   bus.id_load_use_req & ~lu_mask_q;

  always_comb begin
    stall_pat = STALL_NONE;
    unique case (1'b1)
      mem_sel: stall_pat = STALL_MEM;
      mc_sel:  stall_pat = STALL_MC;
      lu_sel:  stall_pat = STALL_LU;
      default: stall_pat = STALL_NONE;
    endcase
  end

  // async drop: nothing is honoured while reset is asserted
  assign stall_w   = resetn ? stall_pat : STALL_NONE;
  assign lu_mask_d = lu_sel;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= RUN;
      mc_cnt_q  <= '0;
      mc_to_q   <= 1'b0;
      lu_mask_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mc_cnt_q  <= mc_cnt_d;
      mc_to_q   <= mc_to_d;
      lu_mask_q <= lu_mask_d;
    end
  end

  inst_hold_buf u_hold (
    .clk        (clk),
    .resetn     (resetn),
    .id_stall_i (stall_w[STG_ID]),
    .rdata_i    (bus.inst_sram_rdata),
    .inst_o     (bus.id_inst)
  );

  assign bus.stall      = stall_w;
  assign bus.mc_timeout = mc_to_q;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] perf_lu_q, perf_lu_d;
  logic [31:0] perf_mc_q, perf_mc_d;
  logic [31:0] perf_mem_q, perf_mem_d;

  assign perf_lu_d  = perf_lu_q + {31'b0, lu_sel};
  assign perf_mc_d  = perf_mc_q + {31'b0, mc_sel};
  assign perf_mem_d = perf_mem_q + {31'b0, mem_sel};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_lu_q  <= '0;
      perf_mc_q  <= '0;
      perf_mem_q <= '0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_mc_q  <= perf_mc_d;
      perf_mem_q <= perf_mem_d;
    end
  end

  assign bus.perf_lu_cnt  = perf_lu_q;
  assign bus.perf_mc_cnt  = perf_mc_q;
  assign bus.perf_mem_cnt = perf_mem_q;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: cycle model compared every negedge,
// plus literal stall/id expectations that pin the model.
module tb_pipe_stall_ctrl;
  import pipe_stall_ctrl_pkg::*;

  localparam int MAX = 64;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  pipe_stall_ctrl_if bus ();

  pipe_stall_ctrl #(
    .MC_MAX_CYCLES (MAX),
    .MC_CNT_W      (7)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  // model: multicycle op tracked by absolute release cycle
  int          cyc;
  int          m_rel;
  bit          m_act, m_to, m_last_lu, m_prev_id, m_busy;
  logic [31:0] m_word, m_id;
  logic [5:0]  m_stall;
  logic [31:0] m_plu, m_pmc, m_pmem;

  always_comb begin
    m_busy  = 1'b0;
    m_stall = 6'h00;
    if (m_act) m_busy = !bus.ex_mc_done && (cyc < m_rel);
    else       m_busy = bus.ex_mc_start;
    if (!resetn)                 m_stall = 6'h00;
    else if (bus.mem_wait_req)   m_stall = 6'h1f;
    else if (m_busy)             m_stall = 6'h0f;
    else if (bus.id_load_use_req && !m_last_lu) m_stall = 6'h07;
    m_id = m_prev_id ? m_word : bus.inst_sram_rdata;
  end

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cyc <= 0; m_rel <= 0; m_act <= 0; m_to <= 0;
      m_last_lu <= 0; m_prev_id <= 0; m_word <= '0;
      m_plu <= '0; m_pmc <= '0; m_pmem <= '0;
    end else begin
      cyc <= cyc + 1;
      if (!m_act && bus.ex_mc_start) begin
        m_act <= 1; m_rel <= cyc + MAX;
      end else if (m_act && (bus.ex_mc_done || cyc >= m_rel)) begin
        m_act <= 0;
        if (!bus.ex_mc_done) m_to <= 1;
      end
      m_last_lu <= (m_stall == 6'h07);
      if (m_stall[2] && !m_prev_id) m_word <= bus.inst_sram_rdata;
      m_prev_id <= m_stall[2];
      if (m_stall == 6'h07) m_plu  <= m_plu + 1;
      if (m_stall == 6'h0f) m_pmc  <= m_pmc + 1;
      if (m_stall == 6'h1f) m_pmem <= m_pmem + 1;
    end
  end

  always @(negedge clk) begin
    chk("stall", 32'(bus.stall), 32'(m_stall));
    chk("id_inst", bus.id_inst, m_id);
    chk("mc_timeout", 32'(bus.mc_timeout), 32'(m_to));
`ifdef STALL_PERF_CNT_EN
    chk("perf_lu", bus.perf_lu_cnt, m_plu);
    chk("perf_mc", bus.perf_mc_cnt, m_pmc);
    chk("perf_mem", bus.perf_mem_cnt, m_pmem);
`endif
  end

  task automatic step(input bit lu, input bit st, input bit dn,
                      input bit mw, input logic [31:0] rd,
                      input int exp_st, input logic [32:0] ei = '0);
    bus.id_load_use_req = lu;
    bus.ex_mc_start     = st;
    bus.ex_mc_done      = dn;
    bus.mem_wait_req    = mw;
    bus.inst_sram_rdata = rd;
    @(negedge clk);
    if (exp_st >= 0) chk("exp_stall", 32'(m_stall), exp_st);
    if (ei[32]) chk("exp_id", m_id, ei[31:0]);
    @(posedge clk);
    #1;
  endtask

  task automatic run_timeout();
    step(0, 1, 0, 0, 32'h0000_E000, 'h0f);
    for (int i = 1; i < MAX; i++)
      step(0, 0, 0, 0, 32'h0000_E000 + i, 'h0f, {1'b1, 32'h0000_E000});
    step(0, 0, 0, 0, 32'h0000_E0FF, 'h00);
    chk("timeout_set", 32'(bus.mc_timeout), 32'd1);
    step(0, 0, 0, 0, 32'h0000_E100, 'h00, {1'b1, 32'h0000_E100});
    chk("timeout_sticky", 32'(bus.mc_timeout), 32'd1);
  endtask

  task automatic run_prio();
    step(0, 1, 0, 0, 32'h0000_00D0, 'h0f);
    step(1, 0, 0, 0, 32'h0000_00D1, 'h0f);
    for (int i = 2; i <= 4; i++)
      step(1, 0, 0, 1, 32'h0000_00D0 + i, 'h1f);
    step(1, 0, 0, 0, 32'h0000_00D5, 'h0f);
    step(1, 0, 0, 0, 32'h0000_00D6, 'h0f);
    step(1, 0, 1, 0, 32'h0000_00D7, 'h07, {1'b1, 32'h0000_00D0});
    step(1, 0, 0, 0, 32'h0000_00D8, 'h00, {1'b1, 32'h0000_00D0});
    step(0, 0, 0, 0, 32'h0000_00D9, 'h00, {1'b1, 32'h0000_00D9});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.id_load_use_req = 1;
    bus.ex_mc_start     = 1;
    bus.ex_mc_done      = 1;
    bus.mem_wait_req    = 1;
    bus.inst_sram_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_timeout", 32'(bus.mc_timeout), 32'h0);
    chk("rst_id", bus.id_inst, 32'hDEAD_BEEF);
    #2 bus.inst_sram_rdata = 32'hCAFE_F00D;
    #1 chk("rst_id_track", bus.id_inst, 32'hCAFE_F00D);
    @(posedge clk); #1;
    bus.id_load_use_req = 0;
    bus.ex_mc_start     = 0;
    bus.ex_mc_done      = 0;
    bus.mem_wait_req    = 0;
    @(posedge clk); #1;
    resetn = 1;

    // load-use: one bubble, ID keeps captured word
    step(1, 0, 0, 0, 32'h8C43_0004, 'h07);
    step(1, 0, 0, 0, 32'h1234_5678, 'h00, {1'b1, 32'h8C43_0004});
    step(0, 0, 0, 0, 32'h1111_1111, 'h00, {1'b1, 32'h1111_1111});

    // multicycle with done 5 cycles after start; stray start ignored
    step(0, 1, 0, 0, 32'h0000_00A0, 'h0f);
    for (int i = 1; i <= 4; i++)
      step(0, i == 2, 0, 0, 32'h0000_00A0 + i, 'h0f,
           {1'b1, 32'h0000_00A0});
    step(0, 0, 1, 0, 32'h0000_00B0, 'h00);
    chk("no_timeout", 32'(bus.mc_timeout), 32'h0);
    step(0, 0, 1, 0, 32'h0000_00B1, 'h00, {1'b1, 32'h0000_00B1});

    run_timeout();
    run_prio();

    // reset in the middle of a multicycle stall
    step(0, 1, 0, 0, 32'h0000_00C0, 'h0f);
    step(0, 0, 0, 0, 32'h0000_00C1, 'h0f);
    resetn = 0;
    bus.inst_sram_rdata = 32'h0000_00C2;
    #1;
    chk("midrst_stall", 32'(bus.stall), 32'h0);
    chk("midrst_id", bus.id_inst, 32'h0000_00C2);
    chk("midrst_timeout", 32'(bus.mc_timeout), 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1;
    step(0, 0, 0, 0, 32'h0000_00C3, 'h00, {1'b1, 32'h0000_00C3});

    run_timeout();
    run_prio();
`ifdef STALL_PERF_CNT_EN
    chk("perf_mc_total", bus.perf_mc_cnt, 32'd68);
    chk("perf_mem_total", bus.perf_mem_cnt, 32'd3);
    chk("perf_lu_total", bus.perf_lu_cnt, 32'd1);
`endif

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
Name: pipe_stall_ctrl

Overview:
Central stall controller for the 5-stage MIPS pipeline (PC, IF, ID, EX, MEM, WB).
- Arbitrates three stall sources: ID load-use hazard, EX multicycle unit, MEM data-SRAM wait.
- Drives the 6-bit stall bus to all stage registers.
- Owns the ID instruction hold buffer, because synchronous inst SRAM data is lost while ID is frozen.

Parameters:
STALL_W, 6, stall bus width; bit0=PC, bit1=IF, bit2=ID, bit3=EX, bit4=MEM, bit5=WB
MC_MAX_CYCLES, 64, max EX multicycle wait before forced release
MC_CNT_W, 7, multicycle wait counter width (must hold MC_MAX_CYCLES)

Ports:
clk  in  1  pipeline clock
resetn  in  1  asynchronous active-low reset
id_load_use_req  in  1  ID operand depends on a load currently in EX
ex_mc_start  in  1  one-cycle pulse: EX multicycle op (mult/div) issued
ex_mc_done  in  1  one-cycle pulse: EX multicycle result valid
mem_wait_req  in  1  data SRAM not ready; MEM must hold
inst_sram_rdata  in  32  instruction SRAM read data
stall  out  STALL_W  stall bus; 1 = stage register holds
id_inst  out  32  instruction presented to ID decode
mc_timeout  out  1  sticky: multicycle op exceeded MC_MAX_CYCLES

Behaviour:
- Clock and reset: single clock clk; resetn asynchronous, active-low.
- Reset values:
  - state=RUN, hold_valid=0, hold_q=0, mc_cnt=0, lu_mask=0, mc_timeout=0.
  - stall=0 (no request is honoured while resetn low).
  - id_inst=inst_sram_rdata.
- FSM states: RUN, MC_WAIT.
  - RUN -> MC_WAIT on ex_mc_start; mc_cnt cleared.
  - MC_WAIT -> RUN on ex_mc_done, or when mc_cnt==MC_MAX_CYCLES-1 (sets mc_timeout).
  - ex_mc_start in MC_WAIT is ignored.
  - ex_mc_done in RUN is ignored.
- mc_busy = (state==RUN & ex_mc_start) | (state==MC_WAIT & ~ex_mc_done & ~timeout_hit).
- Stall bus is combinational, priority highest stage first; pattern is always a contiguous run of ones from bit0:
  - mem_wait_req: 6'b011111
  - else mc_busy: 6'b001111
  - else (id_load_use_req & ~lu_mask): 6'b000111 (EX receives a bubble)
  - else: 6'b000000
- Load-use mask:
  - lu_mask <= 1 on the edge where the load-use pattern was driven; else 0.
  - Guarantees exactly one bubble per hazard.
  - Masked only in the cycle immediately after a taken load-use stall.
- Simultaneous sources:
  - The higher pattern wins.
  - A load-use request hidden under mem/mc stall is not masked; it is re-evaluated when released.
- Multicycle start during mem_wait_req: accepted (state -> MC_WAIT), but the stall bus shows the mem pattern.
- Instruction hold:
  - On an edge with stall[2]=1 and hold_valid=0: hold_q <= inst_sram_rdata, hold_valid <= 1.
  - On an edge with stall[2]=0: hold_valid <= 0.
  - While hold_valid=1, no recapture.
  - id_inst = hold_valid ? hold_q : inst_sram_rdata.
- mc_cnt increments each MC_WAIT cycle; it saturates (never wraps).
- mc_timeout clears only on reset.
- Reset mid-stall: the stall bus drops immediately (async) and the held instruction is discarded.

Optional Feature:
Macro STALL_PERF_CNT_EN.
- Defined:
  - Adds outputs perf_lu_cnt, perf_mc_cnt, perf_mem_cnt (32 bits each).
  - Each counts the cycles its pattern was driven as the winning cause.
  - Counters wrap at 2^32 and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared defines header holds:
  - StallBus width
  - stall pattern constants STALL_NONE, STALL_LU, STALL_MC, STALL_MEM
  - FSM state encodings
  - Stop/NoStop values
- One natural sub-module, inst_hold_buf (hold_q/hold_valid/mux).
- FSM, counters and priority encoder stay in the top block.

Test Plan:
- Reset: resetn=0 with all requests high -> stall=0, mc_timeout=0, id_inst tracks inst_sram_rdata.
- Load-use: id_load_use_req held high for 2 cycles -> stall=000111 for exactly 1 cycle, then 000000. id_inst during the following cycle = word captured at the stall edge (e.g. 0x8C430004), despite rdata changing.
- Multicycle:
  - ex_mc_start, then ex_mc_done 5 cycles later -> stall=001111 from the start cycle through the cycle before done, and 000000 in the done cycle.
  - mc_timeout stays 0.
- Timeout: ex_mc_start with no done -> stall=001111 for 64 cycles, then release; mc_timeout=1 and stays 1 until reset.
- Priority: mem_wait_req=1 in cycles 2-4 during an active MC_WAIT plus a load-use request -> stall=011111 in those cycles, 001111 afterwards until done. The pending load-use then yields one 000111 cycle.
- STALL_PERF_CNT_EN defined: the timeout and priority sequences run back-to-back -> perf_mc_cnt, perf_mem_cnt and perf_lu_cnt equal the counted winning-cause cycles exactly.
